// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one STB/ACK slave between up to
// four masters. A watchdog ends transfers the slave never acknowledges, and a
// RELEASE cycle after every transfer gives the slave one dead cycle per owner.
module bus_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int TIMEOUT   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_MASTERS-1:0]    m_stb,
   input  logic [N_MASTERS-1:0]    m_we,
   input  logic [N_MASTERS*AW-1:0] m_adr,
   input  logic [N_MASTERS*DW-1:0] m_dat_w,
   output logic [N_MASTERS-1:0]    m_ack,
   output logic [N_MASTERS-1:0]    m_err,
   output logic [DW-1:0]           m_dat_r,
   output logic [N_MASTERS-1:0]    grant,
   output logic                    s_stb,
   output logic                    s_we,
   output logic [AW-1:0]           s_adr,
   output logic [DW-1:0]           s_dat_w,
   input  logic [DW-1:0]           s_dat_r,
   input  logic                    s_ack
);

   // Index width for a master number; 2 bits covers the 3- and 4-master cases.
   localparam int IW = (N_MASTERS > 2) ? 2 : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   localparam logic [7:0]           WDOG_LAST = 8'(TIMEOUT - 1);
   localparam logic [N_MASTERS-1:0] ONE_HOT0  = {{(N_MASTERS-1){1'b0}}, 1'b1};

   logic [1:0]           state;
   logic [N_MASTERS-1:0] grant_r;
   logic [IW-1:0]        gidx;      // index of the current owner
   logic [IW-1:0]        last;      // index of the previous owner
   logic [7:0]           wdog;      // BUSY cycles elapsed in this transfer
   logic [IW-1:0]        win;
   logic [IW-1:0]        idx;
   logic                 win_vld;
   logic                 busy;
   logic                 ack_hit;
   logic                 abort_hit;
   logic                 tmo_hit;

   // Per-master views of the packed address / write-data buses.
   logic [AW-1:0] adr_a [N_MASTERS];
   logic [DW-1:0] dat_a [N_MASTERS];

   for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
      assign adr_a[i] = m_adr[i*AW +: AW];
      assign dat_a[i] = m_dat_w[i*DW +: DW];
   end

   // Round-robin pick: scan downward in distance so the requester closest
   // above 'last' is assigned last and therefore wins; 'last' itself ranks lowest.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = N_MASTERS; k >= 1; k--) begin
         idx = IW'((int'(last) + k) % N_MASTERS);
         if (m_stb[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   // Transfer termination causes; ACK outranks abort and timeout.
   assign busy      = (state == BUSY);
   assign ack_hit   = busy & s_ack;
   assign abort_hit = busy & ~s_ack & ~m_stb[gidx];
   assign tmo_hit   = busy & ~s_ack & m_stb[gidx] & (wdog == WDOG_LAST);

   // Slave-side routing is gated by BUSY so idle cycles present all zeros.
   assign s_stb   = busy;
   assign s_we    = busy & m_we[gidx];
   assign s_adr   = busy ? adr_a[gidx] : '0;
   assign s_dat_w = busy ? dat_a[gidx] : '0;

   // Master-side responses steer onto the owner's bit only.
   assign m_ack   = ack_hit ? grant_r : '0;
   assign m_err   = tmo_hit ? grant_r : '0;
   assign m_dat_r = s_dat_r;
   assign grant   = grant_r;

   // Arbitration FSM, grant register, rotation pointer and watchdog.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         grant_r <= '0;
         gidx    <= '0;
         last    <= IW'(N_MASTERS - 1);
         wdog    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state   <= BUSY;
                  grant_r <= ONE_HOT0 << win;
                  gidx    <= win;
                  wdog    <= '0;
               end
            end
            BUSY: begin
               if (ack_hit | abort_hit | tmo_hit) begin
                  state   <= RELEASE;
                  grant_r <= '0;
                  last    <= gidx;
               end else begin
                  wdog <= wdog + 8'd1;
               end
            end
            RELEASE: state <= IDLE;
            default: begin
               state   <= IDLE;
               grant_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one STB/ACK bus slave (e.g. the 32-bit Counter peripheral or any other single-slave port) between up to four bus masters such as the CPU data port and a DMA/VGA fetch unit. It grants one master at a time, routes that master's strobe, address and write data to the slave, and returns ACK and read data. A watchdog terminates transfers the slave never acknowledges, so a dead or absent slave cannot hang the system.

## Interface
Parameters:
- N_MASTERS, 2, number of requesters; legal range 2-4.
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum BUSY cycles without ACK before ERR; legal range 2-255.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m_stb  in  N_MASTERS  per-master request strobe; held until that master's ACK or ERR.
- m_we  in  N_MASTERS  per-master write enable.
- m_adr  in  N_MASTERS*AW  per-master address; master i occupies bits [i*AW +: AW].
- m_dat_w  in  N_MASTERS*DW  per-master write data, same packing.
- m_ack  out  N_MASTERS  one-hot completion pulse to the granted master.
- m_err  out  N_MASTERS  one-hot timeout/error pulse to the granted master.
- m_dat_r  out  DW  read data; s_dat_r broadcast to all masters, valid only with m_ack.
- grant  out  N_MASTERS  one-hot owner of the bus; 0 when no owner.
- s_stb  out  1  strobe to the slave.
- s_we  out  1  write enable to the slave.
- s_adr  out  AW  address to the slave.
- s_dat_w  out  DW  write data to the slave.
- s_dat_r  in  DW  read data from the slave (the slave's DAT_O).
- s_ack  in  1  slave acknowledge (the slave's ACK).

## Operation
- FSM states: IDLE, BUSY, RELEASE.
- IDLE: if any m_stb is high, select the winner by round-robin, searching upward from (last+1) mod N_MASTERS. Register grant and clear the watchdog. Go to BUSY. Otherwise stay in IDLE.
- BUSY: s_stb=1. s_we, s_adr and s_dat_w are combinationally routed from the granted master. The watchdog increments every cycle.
  - s_ack=1: m_ack[g]=1 in the same cycle (combinational from s_ack). Go to RELEASE.
  - Else if m_stb[g]=0 (master abort): no ACK or ERR is issued. Go to RELEASE.
  - Else if watchdog == TIMEOUT-1: m_err[g]=1 for that cycle. Go to RELEASE.
  - s_ack has priority over timeout in the same cycle.
- RELEASE: s_stb=0 and grant is cleared. Set last=g. Go to IDLE. This guarantees one dead bus cycle between owners, so the slave sees each strobe drop.
- While not in BUSY, s_adr, s_dat_w and s_we are 0.
- s_ack arriving outside BUSY is ignored and produces no m_ack.
- The grant does not change during BUSY, even if a higher-priority request arrives.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, grant=0, last=N_MASTERS-1 (master 0 wins the first arbitration), watchdog=0.
  - s_stb=0, s_we=0, s_adr=0, s_dat_w=0, m_ack=0, m_err=0.
- Reset release is sampled synchronously; the first arbitration happens on the first clk edge with reset=1.
- Latency: request seen in IDLE at edge k → grant and s_stb high after edge k+1. With a zero-wait slave, m_ack is high during cycle k+1, RELEASE occupies cycle k+2, and IDLE is reached at edge k+3.
- Minimum 3 cycles per transfer. Continuous requests from all masters are served in strict rotation, with at most N_MASTERS-1 transfers of wait.
- Timeout: m_err asserts in the TIMEOUT-th BUSY cycle (cycle k+TIMEOUT after request at edge k). s_stb drops on the following edge.
- Reset asserted mid-BUSY: s_stb, grant, m_ack and m_err go to 0 immediately (asynchronously). No pending ACK is delivered.
- Master contract: deassert m_stb on the edge after m_ack or m_err. A still-high m_stb is treated as a new request at the next IDLE.

## Test plan
- Single read: master0 m_stb=1, m_adr=0x10. Slave acks in the first BUSY cycle with s_dat_r=0x0000_002A → m_ack=01 and m_dat_r=0x2A in that cycle. grant=01 for exactly one cycle. Back in IDLE 3 cycles after the request.
- Contention: masters 0 and 1 both request continuously against a zero-wait slave → grants alternate 01,10,01,10, each separated by one RELEASE cycle. After reset the first grant goes to master 0.
- Timeout: TIMEOUT=4, s_ack held 0 → m_err[g]=1 in the 4th BUSY cycle with no m_ack. Next grant follows the rotation.
- Abort: master1 drops m_stb in the 2nd BUSY cycle → no ACK or ERR. RELEASE, then IDLE. Pending master0 is granted next.
- Reset mid-transfer: reset=0 during BUSY → s_stb=0 and grant=0 with no clock edge. After release, a master1-only request is granted within 1 edge.
- Late ACK: s_ack pulsed during IDLE or RELEASE → m_ack stays 0 and the FSM state is unchanged.
